// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module  : video_pkg
// Purpose : Shared constants for the character-mode video fetch path. Holds
//           the default raster timing (all H_* / V_* values in character
//           periods or scanlines), the text-grid geometry and the bus widths.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package video_pkg;

  // Default raster timing
  localparam int H_TOTAL_DEF      = 64;
  localparam int H_VISIBLE_DEF    = 40;
  localparam int H_SYNC_START_DEF = 48;
  localparam int H_SYNC_LEN_DEF   = 4;
  localparam int V_TOTAL_DEF      = 260;
  localparam int V_VISIBLE_DEF    = 200;
  localparam int V_SYNC_START_DEF = 224;
  localparam int V_SYNC_LEN_DEF   = 4;

  // Text-grid geometry
  localparam int COLS_PER_ROW  = 40;
  localparam int LINES_PER_ROW = 8;

  // Bus widths
  localparam int VRAM_AW = 10;
  localparam int ROM_AW  = 11;

endpackage
`default_nettype wire

// File: rtl/video_shifter.sv
`default_nettype none
// ============================================================================
// Module  : video_shifter
// Purpose : Display stage of the video pipeline. An 8-bit glyph shifter
//           (MSB first, zero fill) plus the visible flag, and -- when the
//           VIDEO_REVERSE_EN macro is defined -- the reverse-video flag of
//           the character being shown.
// Ports   : clk_16_i     - 16 MHz clock
//           reset_n_i    - asynchronous active-low reset
//           shift_en_i   - pixel shift enable (8 MHz bus clock level)
//           load_i       - boundary tick: load glyph and flags
//           glyph_i      - glyph byte to load
//           vis_i        - visible flag of the fetched character
//           rev_i        - reverse flag of the fetched character
//           video_o      - pixel, 1 = lit
//           display_en_o - displayed pixel is inside the visible area
// Config  : VIDEO_REVERSE_EN - adds the reverse flop and the pixel XOR
// Revision: 1.0  initial release
// ============================================================================
module video_shifter (
  input  logic       clk_16_i,
  input  logic       reset_n_i,
  input  logic       shift_en_i,
  input  logic       load_i,
  input  logic [7:0] glyph_i,
  input  logic       vis_i,
  input  logic       rev_i,
  output logic       video_o,
  output logic       display_en_o
);

  logic [7:0] shift_q;
  logic       vis_q;

  // A load edge takes priority: a tick that coincides with a shift enable
  // presents the glyph MSB instead of shifting it away.
  always_ff @(posedge clk_16_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      shift_q <= 8'h00;
      vis_q   <= 1'b0;
    end else if (load_i) begin
      shift_q <= glyph_i;
      vis_q   <= vis_i;
    end else if (shift_en_i) begin
      shift_q <= {shift_q[6:0], 1'b0};
    end
  end

`ifdef VIDEO_REVERSE_EN
  logic rev_q;

  always_ff @(posedge clk_16_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rev_q <= 1'b0;
    end else if (load_i) begin
      rev_q <= rev_i;
    end
  end

  // Blanked pixels stay dark even for reversed characters.
  assign video_o = vis_q & (shift_q[7] ^ rev_q);
`else
  logic unused_rev;
  assign unused_rev = rev_i;

  assign video_o = vis_q & shift_q[7];
`endif

  assign display_en_o = vis_q;

endmodule
`default_nettype wire

// File: rtl/video_fetch.sv
`default_nettype none
// ============================================================================
// Module  : video_fetch
// Purpose : Character-mode video fetch and pixel serializer. Uses the video
//           RAM / character ROM bus slots issued once per 1 us bus cycle to
//           fetch a character code and its glyph byte, then serializes the
//           glyph at 8 MHz together with hsync/vsync for a 40x25 display.
// Ports   : clk_16_i           - 16 MHz clock (sole clock)
//           reset_n_i          - asynchronous active-low reset
//           clk_8_i            - 8 MHz bus clock, used as pixel shift enable
//           video_ram_enable_i - video RAM bus slot
//           video_rom_enable_i - character ROM bus slot
//           graphic_i          - character set select (ROM A10)
//           data_i[7:0]        - shared data bus
//           vram_addr_o[9:0]   - video RAM address
//           rom_addr_o[10:0]   - character ROM address
//           video_o            - pixel, 1 = lit
//           hsync_o / vsync_o  - active-high syncs
//           display_en_o       - displayed pixel is in the visible area
// Config  : VIDEO_REVERSE_EN - char bit 7 selects reverse video
// Revision: 1.0  initial release
// ============================================================================
module video_fetch
  import video_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_VISIBLE    = H_VISIBLE_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int H_SYNC_LEN   = H_SYNC_LEN_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_VISIBLE    = V_VISIBLE_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int V_SYNC_LEN   = V_SYNC_LEN_DEF
) (
  input  logic               clk_16_i,
  input  logic               reset_n_i,
  input  logic               clk_8_i,
  input  logic               video_ram_enable_i,
  input  logic               video_rom_enable_i,
  input  logic               graphic_i,
  input  logic [7:0]         data_i,
  output logic [VRAM_AW-1:0] vram_addr_o,
  output logic [ROM_AW-1:0]  rom_addr_o,
  output logic               video_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               display_en_o
);

  localparam int COL_W  = $clog2(H_TOTAL);
  localparam int LINE_W = $clog2(V_TOTAL);
  localparam int ROWB_W = VRAM_AW + 1;  // row base runs past 1023 in vblank
  localparam int SUB_W  = $clog2(LINES_PER_ROW);

  localparam logic [COL_W-1:0]  C_COL_LAST  = COL_W'(H_TOTAL - 1);
  localparam logic [COL_W-1:0]  C_H_VIS     = COL_W'(H_VISIBLE);
  localparam logic [COL_W-1:0]  C_HS_BEG    = COL_W'(H_SYNC_START);
  localparam logic [COL_W-1:0]  C_HS_END    = COL_W'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [LINE_W-1:0] C_LINE_LAST = LINE_W'(V_TOTAL - 1);
  localparam logic [LINE_W-1:0] C_V_VIS     = LINE_W'(V_VISIBLE);
  localparam logic [LINE_W-1:0] C_VS_BEG    = LINE_W'(V_SYNC_START);
  localparam logic [LINE_W-1:0] C_VS_END    = LINE_W'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [SUB_W-1:0]  C_SUB_LAST  = SUB_W'(LINES_PER_ROW - 1);
  localparam logic [ROWB_W-1:0] C_ROW_STEP  = ROWB_W'(COLS_PER_ROW);

  // Bus capture
  logic [7:0] char_q;
  logic [7:0] glyph_q;
  logic       rom_en_q;
  logic       tick;

  // Raster state
  logic [COL_W-1:0]   col_q,  col_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [ROWB_W-1:0]  rowb_q, rowb_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               fetch_vis;
  logic               next_vis;

  always_ff @(posedge clk_16_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      char_q   <= 8'h00;
      glyph_q  <= 8'h00;
      rom_en_q <= 1'b0;
    end else begin
      rom_en_q <= video_rom_enable_i;
      if (video_ram_enable_i) char_q  <= data_i;
      if (video_rom_enable_i) glyph_q <= data_i;
    end
  end

  // The falling edge of the ROM slot closes a character period; the glyph
  // byte is complete there. If the slots stop, no tick is ever produced.
  assign tick = rom_en_q & ~video_rom_enable_i;

  always_comb begin
    col_d       = (col_q == C_COL_LAST) ? '0 : col_q + 1'b1;
    line_d      = line_q;
    rowb_d      = rowb_q;
    if (col_q == C_COL_LAST) begin
      if (line_q == C_LINE_LAST) begin
        line_d = '0;
        rowb_d = '0;
      end else begin
        line_d = line_q + 1'b1;
        if (line_q[SUB_W-1:0] == C_SUB_LAST) rowb_d = rowb_q + C_ROW_STEP;
      end
    end

    fetch_vis = (col_q < C_H_VIS) && (line_q < C_V_VIS);
    next_vis  = (col_d < C_H_VIS) && (line_d < C_V_VIS);

    // Address for the next fetch; held across blanking.
    vram_addr_d = vram_addr_q;
    if (next_vis) vram_addr_d = rowb_d[VRAM_AW-1:0] + VRAM_AW'(col_d);

    // Syncs describe the column/line whose pixels enter the display stage
    // at this tick, keeping them aligned with video_o.
    hsync_d = (col_q >= C_HS_BEG) && (col_q < C_HS_END);
    vsync_d = (line_q >= C_VS_BEG) && (line_q < C_VS_END);
  end

  always_ff @(posedge clk_16_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      col_q       <= '0;
      line_q      <= '0;
      rowb_q      <= '0;
      vram_addr_q <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
    end else if (tick) begin
      col_q       <= col_d;
      line_q      <= line_d;
      rowb_q      <= rowb_d;
      vram_addr_q <= vram_addr_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign vram_addr_o = vram_addr_q;
  assign rom_addr_o  = {graphic_i, char_q[6:0], line_q[SUB_W-1:0]};
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;

  video_shifter u_shifter (
    .clk_16_i     (clk_16_i),
    .reset_n_i    (reset_n_i),
    .shift_en_i   (clk_8_i),
    .load_i       (tick),
    .glyph_i      (glyph_q),
    .vis_i        (fetch_vis),
    .rev_i        (char_q[7]),
    .video_o      (video_o),
    .display_en_o (display_en_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_video_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_video_fetch
// Purpose : Self-checking bench for video_fetch. Pixel expectations are
//           queued when a fetch is driven and popped as the pixels appear;
//           raster state is checked against a small independent model.
//           Honors VIDEO_REVERSE_EN for the expected pixel polarity.
// Revision: 1.0  initial release
// ============================================================================
module tb_video_fetch;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        clk_8_i = 1'b0;
  logic        video_ram_enable_i = 1'b0;
  logic        video_rom_enable_i = 1'b0;
  logic        graphic_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic [9:0]  vram_addr_o;
  logic [10:0] rom_addr_o;
  logic        video_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        display_en_o;

  always #31 clk = ~clk;

  video_fetch dut (
    .clk_16_i           (clk),
    .reset_n_i          (reset_n_i),
    .clk_8_i            (clk_8_i),
    .video_ram_enable_i (video_ram_enable_i),
    .video_rom_enable_i (video_rom_enable_i),
    .graphic_i          (graphic_i),
    .data_i             (data_i),
    .vram_addr_o        (vram_addr_o),
    .rom_addr_o         (rom_addr_o),
    .video_o            (video_o),
    .hsync_o            (hsync_o),
    .vsync_o            (vsync_o),
    .display_en_o       (display_en_o)
  );

`ifdef VIDEO_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  int   tests  = 0;
  int   failed = 0;
  logic exp_pix_q[$];

  // Raster model: column/line of the next fetch, held address, display stage
  int   m_col, m_line, m_addr;
  logic m_hs, m_vs, m_dv;
  int   hs_cyc, hs_per, vs_per;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input bit check_async);
    @(negedge clk);
    video_ram_enable_i = 1'b0;
    video_rom_enable_i = 1'b0;
    clk_8_i   = 1'b0;
    data_i    = 8'h00;
    graphic_i = 1'b1;
    #1 reset_n_i = 1'b0;
    #1;
    if (check_async) begin
      check("rst_vram_addr", vram_addr_o, 0);
      check("rst_rom_addr", rom_addr_o, 11'h400);
      check("rst_video", video_o, 0);
      check("rst_hsync", hsync_o, 0);
      check("rst_vsync", vsync_o, 0);
      check("rst_display_en", display_en_o, 0);
    end
    repeat (3) @(negedge clk);
    reset_n_i = 1'b1;
    graphic_i = 1'b0;
    m_col = 0; m_line = 0; m_addr = 0;
    m_hs = 1'b0; m_vs = 1'b0; m_dv = 1'b0;
    // The six pixels still to come from the (empty) previous period
    exp_pix_q.delete();
    repeat (6) exp_pix_q.push_back(1'b0);
  endtask

  // One character period. Full speed: 16 clocks, RAM slot on edges 2..5, ROM
  // slot on edges 8..11, tick on edge 12 (clk_8 high). Fast: 2 clocks.
  task automatic period(input logic [7:0] ch, input logic [7:0] gl, input bit fast);
    bit   fvis;
    int   n;
    logic pix;
    fvis = (m_col < 40) && (m_line < 200);
    n    = fast ? 2 : 16;
    if (!fast)
      for (int i = 7; i >= 0; i--) exp_pix_q.push_back(fvis & (gl[i] ^ (REV & ch[7])));
    for (int e = 0; e < n; e++) begin
      @(negedge clk);
      if (e == 0) begin
        check("vram_addr", vram_addr_o, m_addr);
        check("hsync", hsync_o, m_hs);
        check("vsync", vsync_o, m_vs);
        check("display_en", display_en_o, m_dv);
        if (m_line == 200 && m_col == 0) check("last_vis_addr", vram_addr_o, 999);
        if (hsync_o) hs_per++;
        if (vsync_o) vs_per++;
      end
      if (!fast) begin
        if (hsync_o) hs_cyc++;
        if (e == 11) check("rom_addr", rom_addr_o, {graphic_i, ch[6:0], 3'(m_line % 8)});
        if (e % 2 == 1) begin
          pix = (exp_pix_q.size() > 0) ? exp_pix_q.pop_front() : 1'bx;
          check("pixel", video_o, pix);
        end
        clk_8_i            = (e % 2 == 0);
        video_ram_enable_i = (e >= 2 && e <= 5);
        video_rom_enable_i = (e >= 8 && e <= 11);
      end else begin
        clk_8_i            = 1'b0;
        video_ram_enable_i = (e == 0);
        video_rom_enable_i = (e == 0);
      end
      data_i = video_ram_enable_i ? ch : (video_rom_enable_i ? gl : 8'h00);
    end
    m_hs = (m_col >= 48) && (m_col < 52);
    m_vs = (m_line >= 224) && (m_line < 228);
    m_dv = fvis;
    m_col++;
    if (m_col == 64) begin
      m_col = 0;
      m_line++;
      if (m_line == 260) m_line = 0;
    end
    if (m_col < 40 && m_line < 200) m_addr = (m_line / 8) * 40 + m_col;
  endtask

  task automatic rand_periods(input int count);
    for (int k = 0; k < count; k++) begin
      graphic_i = 1'($urandom_range(0, 1));
      period(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    end
  endtask

  task automatic stall(input int cycles);
    @(negedge clk);
    video_ram_enable_i = 1'b0;
    video_rom_enable_i = 1'b0;
    clk_8_i = 1'b0;
    data_i  = 8'h00;
    repeat (cycles) @(negedge clk);
    check("stall_vram_addr", vram_addr_o, m_addr);
    check("stall_hsync", hsync_o, m_hs);
    check("stall_vsync", vsync_o, m_vs);
    check("stall_display_en", display_en_o, m_dv);
  endtask

  initial begin
    hs_cyc = 0; hs_per = 0; vs_per = 0;

    // Reset state, then scanline 0 at full speed
    do_reset(1'b1);
    graphic_i = 1'b0;
    period(8'h01, 8'hA5, 1'b0);   // single glyph, rom_addr 0x008
    period(8'h81, 8'h0F, 1'b0);   // reverse candidate
    rand_periods(62);             // rest of scanline 0, incl. blanking
    check("hsync_width_cycles", hs_cyc, 64);

    // Stalled slots mid-scanline, then resume
    rand_periods(5);
    stall(100);
    rand_periods(5);

    // Reset in the middle of hsync
    rand_periods(41);
    check("hsync_pre_reset", hsync_o, 1);
    do_reset(1'b1);
    rand_periods(4);

    // One whole frame with compressed bus periods
    do_reset(1'b0);
    hs_per = 0; vs_per = 0;
    for (int k = 0; k < 64 * 260; k++) period(8'($urandom_range(0, 255)), 8'h00, 1'b1);
    @(negedge clk);
    check("frame_wrap_addr", vram_addr_o, 0);
    check("hsync_periods", hs_per, 4 * 260);
    check("vsync_periods", vs_per, 4 * 64);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
